control_sequencer: RTL and testbench

//  Instruction sequencer that drives the ALU/bus control lines (doSubtract, assertBarE) and consumes its status (aIsZero, flagCarry).

---
 rtl/seq_pkg.sv | 67 ++++++
 rtl/seq_decode.sv | 88 ++++++++
 rtl/control_sequencer.sv | 123 ++++++++++++
 tb/tb_control_sequencer.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/seq_pkg.sv
// ---------------------------------------------------------------------------
// seq_pkg
//   Shared definitions for the control sequencer: the sequencer state enum,
//   instruction-word field positions and encodings, and small helpers that
//   pull fields out of the instruction register.
//
//   IR layout:  [7:6] src  [5:4] dst  [3:2] cond  [1] sub  [0] halt
// ---------------------------------------------------------------------------
package seq_pkg;

  typedef enum logic [1:0] {
    FETCH  = 2'd0,
    EXEC   = 2'd1,
    HALTED = 2'd2
  } state_t;

  // Field positions inside the 8-bit instruction word
  localparam int unsigned IR_SRC_LSB  = 6;
  localparam int unsigned IR_DST_LSB  = 4;
  localparam int unsigned IR_COND_LSB = 2;
  localparam int unsigned IR_SUB_BIT  = 1;
  localparam int unsigned IR_HALT_BIT = 0;

  // Source encodings (who drives dbus)
  localparam logic [1:0] SRC_IMM = 2'b00;
  localparam logic [1:0] SRC_ALU = 2'b01;
  localparam logic [1:0] SRC_A   = 2'b10;
  localparam logic [1:0] SRC_B   = 2'b11;

  // Destination encodings (who takes dbus)
  localparam logic [1:0] DST_A   = 2'b00;
  localparam logic [1:0] DST_B   = 2'b01;
  localparam logic [1:0] DST_OUT = 2'b10;
  localparam logic [1:0] DST_PC  = 2'b11;

  // Condition encodings
  localparam logic [1:0] COND_ALWAYS   = 2'b00;
  localparam logic [1:0] COND_AZERO    = 2'b01;
  localparam logic [1:0] COND_CARRY    = 2'b10;
  localparam logic [1:0] COND_NOCARRY  = 2'b11;

  function automatic logic [1:0] ir_src(input logic [7:0] ir);
    return ir[IR_SRC_LSB +: 2];
  endfunction

  function automatic logic [1:0] ir_dst(input logic [7:0] ir);
    return ir[IR_DST_LSB +: 2];
  endfunction

  function automatic logic [1:0] ir_cond(input logic [7:0] ir);
    return ir[IR_COND_LSB +: 2];
  endfunction

  function automatic logic cond_true(input logic [1:0] cond,
                                     input logic       a_is_zero,
                                     input logic       flag_carry);
    logic r;
    case (cond)
      COND_ALWAYS:  r = 1'b1;
      COND_AZERO:   r = a_is_zero;
      COND_CARRY:   r = flag_carry;
      default:      r = ~flag_carry;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/seq_decode.sv
// ---------------------------------------------------------------------------
// seq_decode
//   Pure combinational decode of IR + ALU flags + sequencer state into the
//   bus-enable / load strobes and the PC-control hints used by the top.
//   Everything is inactive outside EXEC, so FETCH and HALTED (and reset,
//   which forces FETCH) never drive the bus.
//
// Ports
//   i_ir           instruction register
//   i_state        current sequencer state
//   i_a_is_zero    A register == 0
//   i_flag_carry   latched ALU carry
//   o_take         EXEC and condition true
//   o_do_subtract  ALU subtract select (IR sub bit for the whole EXEC)
//   o_bar_e/rom/a/b active-low bus driver enables (at most one low)
//   o_load_a/b/out active-high register load strobes
//   o_load_pc      PC takes dbus at the next edge
//   o_src_imm      EXEC of an immediate-source instruction (PC must advance)
//   o_halt         EXEC of an instruction with the halt bit set
// ---------------------------------------------------------------------------
module seq_decode
  import seq_pkg::*;
(
  input  logic [7:0] i_ir,
  input  state_t     i_state,
  input  logic       i_a_is_zero,
  input  logic       i_flag_carry,
  output logic       o_take,
  output logic       o_do_subtract,
  output logic       o_bar_e,
  output logic       o_bar_rom,
  output logic       o_bar_a,
  output logic       o_bar_b,
  output logic       o_load_a,
  output logic       o_load_b,
  output logic       o_load_out,
  output logic       o_load_pc,
  output logic       o_src_imm,
  output logic       o_halt
);

  logic       w_exec;
  logic [1:0] w_src;
  logic [1:0] w_dst;

  assign w_exec = (i_state == EXEC);
  assign w_src  = ir_src(i_ir);
  assign w_dst  = ir_dst(i_ir);

  always_comb begin
    o_take        = 1'b0;
    o_do_subtract = 1'b0;
    o_bar_e       = 1'b1;
    o_bar_rom     = 1'b1;
    o_bar_a       = 1'b1;
    o_bar_b       = 1'b1;
    o_load_a      = 1'b0;
    o_load_b      = 1'b0;
    o_load_out    = 1'b0;
    o_load_pc     = 1'b0;
    o_src_imm     = 1'b0;
    o_halt        = 1'b0;

    if (w_exec) begin
      o_take        = cond_true(ir_cond(i_ir), i_a_is_zero, i_flag_carry);
      // Subtract is held independent of take so the ALU output stays stable
      o_do_subtract = i_ir[IR_SUB_BIT];
      o_src_imm     = (w_src == SRC_IMM);
      o_halt        = i_ir[IR_HALT_BIT];

      if (o_take) begin
        case (w_src)
          SRC_IMM: o_bar_rom = 1'b0;
          SRC_ALU: o_bar_e   = 1'b0;
          SRC_A:   o_bar_a   = 1'b0;
          default: o_bar_b   = 1'b0;
        endcase
        case (w_dst)
          DST_A:   o_load_a   = 1'b1;
          DST_B:   o_load_b   = 1'b1;
          DST_OUT: o_load_out = 1'b1;
          default: o_load_pc  = 1'b1;
        endcase
      end
    end
  end

endmodule

// File: rtl/control_sequencer.sv
// ---------------------------------------------------------------------------
// control_sequencer
//   Two-clock (FETCH, EXEC) instruction sequencer. Each instruction moves one
//   byte across dbus from a source (ROM immediate, ALU, A, B) to a
//   destination (A, B, OUT, PC), optionally conditioned on ALU status.
//   Owns PC, IR and the sequencer state; strobes are decoded by seq_decode.
//
// Ports
//   clk           system clock, all state on posedge
//   reset         asynchronous, active-high
//   rom_addr      ROM address (= PC)
//   rom_data      ROM read data
//   dbus          shared data bus, sampled for PC loads
//   aIsZero       A register == 0
//   flagCarry     latched ALU carry
//   doSubtract    ALU subtract select
//   assertBarE    active-low ALU -> dbus
//   assertBarRom  active-low ROM -> dbus
//   assertBarA    active-low A -> dbus
//   assertBarB    active-low B -> dbus
//   loadA/B/Out   active-high load strobes
//   halted        sequencer stopped
// ---------------------------------------------------------------------------
module control_sequencer
  import seq_pkg::*;
#(
  parameter int unsigned          PC_WIDTH     = 8,
  parameter logic [PC_WIDTH-1:0]  RESET_VECTOR = '0
) (
  input  logic                clk,
  input  logic                reset,
  output logic [PC_WIDTH-1:0] rom_addr,
  input  logic [7:0]          rom_data,
  input  logic [7:0]          dbus,
  input  logic                aIsZero,
  input  logic                flagCarry,
  output logic                doSubtract,
  output logic                assertBarE,
  output logic                assertBarRom,
  output logic                assertBarA,
  output logic                assertBarB,
  output logic                loadA,
  output logic                loadB,
  output logic                loadOut,
  output logic                halted
);

  localparam logic [PC_WIDTH-1:0] PC_ONE = PC_WIDTH'(1);

  state_t              r_state;
  state_t              w_state_nxt;
  logic [PC_WIDTH-1:0] r_pc;
  logic [PC_WIDTH-1:0] w_pc_nxt;
  logic [7:0]          r_ir;
  logic [7:0]          w_ir_nxt;
  logic [PC_WIDTH-1:0] w_dbus_pc;

  logic w_take;
  logic w_load_pc;
  logic w_src_imm;
  logic w_halt;

  assign w_dbus_pc = PC_WIDTH'(dbus);

  seq_decode u_decode (
    .i_ir          (r_ir),
    .i_state       (r_state),
    .i_a_is_zero   (aIsZero),
    .i_flag_carry  (flagCarry),
    .o_take        (w_take),
    .o_do_subtract (doSubtract),
    .o_bar_e       (assertBarE),
    .o_bar_rom     (assertBarRom),
    .o_bar_a       (assertBarA),
    .o_bar_b       (assertBarB),
    .o_load_a      (loadA),
    .o_load_b      (loadB),
    .o_load_out    (loadOut),
    .o_load_pc     (w_load_pc),
    .o_src_imm     (w_src_imm),
    .o_halt        (w_halt)
  );

  // PC addresses both the opcode (FETCH) and the immediate byte (EXEC)
  assign rom_addr = r_pc;
  assign halted   = (r_state == HALTED);

  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_ir_nxt    = r_ir;
    case (r_state)
      FETCH: begin
        w_ir_nxt    = rom_data;
        w_pc_nxt    = r_pc + PC_ONE;
        w_state_nxt = EXEC;
      end
      EXEC: begin
        // A taken PC load wins over the immediate-consumption increment
        if (w_load_pc)
          w_pc_nxt = w_dbus_pc;
        else if (w_src_imm)
          w_pc_nxt = r_pc + PC_ONE;
        w_state_nxt = w_halt ? HALTED : FETCH;
      end
      HALTED: w_state_nxt = HALTED;
      default: w_state_nxt = FETCH;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= FETCH;
      r_pc    <= RESET_VECTOR;
      r_ir    <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
      r_ir    <= w_ir_nxt;
    end
  end

endmodule

// File: tb/tb_control_sequencer.sv
module tb_control_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] rom_addr;
  logic [7:0] rom_data;
  logic [7:0] dbus;
  logic       aIsZero, flagCarry;
  logic       doSubtract, assertBarE, assertBarRom, assertBarA, assertBarB;
  logic       loadA, loadB, loadOut, halted;

  logic [7:0] rom [256];
  logic [7:0] a_reg, b_reg, alu_val, bus_idle;

  int n_cmp = 0;
  int n_err = 0;

  // strobe vector: {sub, barE, barRom, barA, barB, ldA, ldB, ldOut, halted}
  localparam logic [8:0] IDLE      = 9'b0_1111_000_0;
  localparam logic [8:0] HALT_IDLE = 9'b0_1111_000_1;

  control_sequencer #(.PC_WIDTH(8), .RESET_VECTOR(8'h00)) dut (
    .clk(clk), .reset(reset), .rom_addr(rom_addr), .rom_data(rom_data),
    .dbus(dbus), .aIsZero(aIsZero), .flagCarry(flagCarry),
    .doSubtract(doSubtract), .assertBarE(assertBarE), .assertBarRom(assertBarRom),
    .assertBarA(assertBarA), .assertBarB(assertBarB), .loadA(loadA),
    .loadB(loadB), .loadOut(loadOut), .halted(halted)
  );

  always #5 clk = ~clk;

  assign rom_data = rom[rom_addr];

  always_comb begin
    dbus = bus_idle;
    if (!assertBarRom)    dbus = rom_data;
    else if (!assertBarE) dbus = alu_val;
    else if (!assertBarA) dbus = a_reg;
    else if (!assertBarB) dbus = b_reg;
  end

  function automatic logic [8:0] strobes();
    return {doSubtract, assertBarE, assertBarRom, assertBarA, assertBarB,
            loadA, loadB, loadOut, halted};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
  endtask

  typedef struct {
    logic [7:0] ir;
    logic       az;
    logic       fc;
    logic [8:0] exp_s;
    logic [7:0] exp_pc;
    logic       exp_halt;
  } vec_t;

  vec_t vecs[10];

  // Instruction-level reference: outcome of one EXEC given IR and flags
  logic [7:0] m_ir;
  int unsigned m_pc;

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1; aIsZero = 1'b0; flagCarry = 1'b0;
    a_reg = 8'h11; b_reg = 8'h33; alu_val = 8'h77; bus_idle = 8'hC3;
    for (int i = 0; i < 256; i++) rom[i] = 8'h00;

    // ------------------------------------------------------------ table
    // ROM[0]=ir, ROM[1]=8'h5C; A=11, B=33, ALU=77
    vecs[0] = '{8'h00, 1'b0, 1'b0, 9'b0_1011_100_0, 8'h02, 1'b0}; // IMM->A
    vecs[1] = '{8'h42, 1'b0, 1'b0, 9'b1_0111_100_0, 8'h01, 1'b0}; // ALU->A sub
    vecs[2] = '{8'h34, 1'b1, 1'b0, 9'b0_1011_000_0, 8'h5C, 1'b0}; // IMM->PC az=1
    vecs[3] = '{8'h34, 1'b0, 1'b0, 9'b0_1111_000_0, 8'h02, 1'b0}; // IMM->PC az=0
    vecs[4] = '{8'h98, 1'b0, 1'b1, 9'b0_1101_010_0, 8'h01, 1'b0}; // A->B if C
    vecs[5] = '{8'h9A, 1'b0, 1'b0, 9'b1_1111_000_0, 8'h01, 1'b0}; // A->B if C, no
    vecs[6] = '{8'hEC, 1'b0, 1'b0, 9'b0_1110_001_0, 8'h01, 1'b0}; // B->OUT if !C
    vecs[7] = '{8'hF0, 1'b0, 1'b0, 9'b0_1110_000_0, 8'h33, 1'b0}; // B->PC
    vecs[8] = '{8'h80, 1'b0, 1'b0, 9'b0_1101_100_0, 8'h01, 1'b0}; // A->A
    vecs[9] = '{8'h5D, 1'b0, 1'b1, 9'b0_1111_000_0, 8'h01, 1'b1}; // halt, not taken

    for (int v = 0; v < 10; v++) begin
      rom[0] = vecs[v].ir; rom[1] = 8'h5C;
      aIsZero = vecs[v].az; flagCarry = vecs[v].fc;
      do_reset();
      chk($sformatf("vec%0d_fetch_addr", v), rom_addr, 32'h0);
      chk($sformatf("vec%0d_fetch_strobes", v), strobes(), IDLE);
      tick();
      chk($sformatf("vec%0d_exec_strobes", v), strobes(), vecs[v].exp_s);
      chk($sformatf("vec%0d_exec_addr", v), rom_addr, 32'h1);
      tick();
      chk($sformatf("vec%0d_pc", v), rom_addr, vecs[v].exp_pc);
      chk($sformatf("vec%0d_halted", v), halted, vecs[v].exp_halt);
    end

    // ------------------------------------------------ reset mid-EXEC
    rom[0] = 8'h10; rom[1] = 8'h99; aIsZero = 1'b0; flagCarry = 1'b0;
    do_reset();
    tick();
    chk("midrst_pre_loadB", loadB, 1'b1);
    chk("midrst_pre_barRom", assertBarRom, 1'b0);
    reset = 1'b1;
    #1;
    chk("midrst_strobes", strobes(), IDLE);
    tick();
    chk("midrst_held_strobes", strobes(), IDLE);
    reset = 1'b0;
    #1;
    chk("midrst_pc", rom_addr, 32'h0);
    chk("midrst_fetch_strobes", strobes(), IDLE);
    tick();
    chk("midrst_exec_loadB", loadB, 1'b1);

    // ------------------------------------------------ PC wrap
    for (int i = 0; i < 256; i++) rom[i] = 8'h00;
    rom[0] = 8'h30; rom[1] = 8'hFF; rom[255] = 8'hA0;
    do_reset();
    tick(); tick();
    chk("wrap_pc_ff", rom_addr, 32'hFF);
    tick();
    chk("wrap_pc_00", rom_addr, 32'h00);
    chk("wrap_strobes", strobes(), 9'b0_1101_001_0);

    // ------------------------------------------------ halt and freeze
    rom[0] = 8'hA1; rom[1] = 8'h00;
    do_reset();
    tick();
    chk("halt_exec_loadOut", loadOut, 1'b1);
    chk("halt_exec_halted", halted, 1'b0);
    tick();
    chk("halt_strobes", strobes(), HALT_IDLE);
    chk("halt_pc", rom_addr, 32'h1);
    for (int k = 0; k < 10; k++) begin
      aIsZero = 1'($urandom); flagCarry = 1'($urandom);
      tick();
      chk($sformatf("halt_frozen%0d_pc", k), rom_addr, 32'h1);
      chk($sformatf("halt_frozen%0d_strobes", k), strobes(), HALT_IDLE);
    end

    // ------------------------------------------------ random programs
    for (int i = 0; i < 256; i++) begin
      rom[i] = 8'($urandom);
      if ($urandom_range(0, 15) != 0) rom[i][0] = 1'b0;
    end
    do_reset();
    m_pc = 0;
    for (int n = 0; n < 400; n++) begin
      logic [1:0] src, dst, cnd;
      logic       take;
      logic [3:0] bars;  // {E, Rom, A, B}
      logic [2:0] lds;   // {A, B, OUT}
      logic [7:0] busv;

      chk("rnd_fetch_addr", rom_addr, m_pc);
      chk("rnd_fetch_strobes", strobes(), IDLE);
      m_ir = rom[m_pc];
      m_pc = (m_pc + 1) % 256;
      tick();
      aIsZero = 1'($urandom); flagCarry = 1'($urandom);
      a_reg = 8'($urandom); b_reg = 8'($urandom);
      alu_val = 8'($urandom); bus_idle = 8'($urandom);
      #1;
      src = m_ir[7:6]; dst = m_ir[5:4]; cnd = m_ir[3:2];
      case (cnd)
        2'd0: take = 1'b1;
        2'd1: take = aIsZero;
        2'd2: take = flagCarry;
        default: take = !flagCarry;
      endcase
      bars = 4'b1111; lds = 3'b000;
      case (src)
        2'd0: busv = rom[m_pc];
        2'd1: busv = alu_val;
        2'd2: busv = a_reg;
        default: busv = b_reg;
      endcase
      if (take) begin
        if (src == 2'd0) bars[2] = 1'b0;
        if (src == 2'd1) bars[3] = 1'b0;
        if (src == 2'd2) bars[1] = 1'b0;
        if (src == 2'd3) bars[0] = 1'b0;
        if (dst == 2'd0) lds[2] = 1'b1;
        if (dst == 2'd1) lds[1] = 1'b1;
        if (dst == 2'd2) lds[0] = 1'b1;
      end
      chk("rnd_exec_strobes", strobes(), {m_ir[1], bars, lds, 1'b0});
      chk("rnd_exec_addr", rom_addr, m_pc);
      chk("rnd_one_driver",
          32'($countones({~assertBarE, ~assertBarRom, ~assertBarA, ~assertBarB}) <= 1), 32'h1);
      if (dst == 2'd3 && take) m_pc = busv;
      else if (src == 2'd0)    m_pc = (m_pc + 1) % 256;
      tick();
      if (m_ir[0]) begin
        chk("rnd_halted", halted, 1'b1);
        chk("rnd_halt_pc", rom_addr, m_pc);
        do_reset();
        m_pc = 0;
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
